// File: rtl/multiplier_unsigned_seq.sv
// Sequential unsigned multiplier: radix-4 digit pairs through a registered 2x2 multiplier, shift-accumulated.
// out_valid rises N*N+2 cycles after accept; q holds in DONE until out_ready.
module multiplier_unsigned_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   q,
  output logic                 busy
);

  localparam int N  = WIDTH / 2;
  localparam int NN = N * N;
  localparam int PW = $clog2(NN + 1);
  localparam int SW = $clog2(2 * WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [PW-1:0]        p;
  logic [3:0]           prod;
  logic [SW-1:0]        prod_sh;
  logic                 prod_vld;
  logic [2*WIDTH-1:0]   acc;

  logic [1:0]           da;
  logic [1:0]           db;
  logic [SW-1:0]        sh;
  logic [2*WIDTH-1:0]   addend;
  int                   pi;
  int                   di;
  int                   dj;

  // p == NN is the flush step: nothing issued, so the index is clamped in range
  always_comb begin
    pi     = (p < PW'(NN)) ? int'(p) : 0;
    di     = pi / N;
    dj     = pi % N;
    da     = a_r[2*di +: 2];
    db     = b_r[2*dj +: 2];
    sh     = SW'(2 * (di + dj));
    addend = (2*WIDTH)'(prod) << prod_sh;
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state == RUN) || (state == DRAIN);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state    <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      p        <= '0;
      prod     <= '0;
      prod_sh  <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            acc      <= '0;
            p        <= '0;
            prod_vld <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          if (prod_vld)
            acc <= acc + addend;
          if (p < PW'(NN)) begin
            prod     <= 4'(da) * 4'(db);
            prod_sh  <= sh;
            prod_vld <= 1'b1;
            p        <= p + PW'(1);
          end else begin
            prod_vld <= 1'b0;
            state    <= DRAIN;
          end
        end
        DRAIN: begin
          q     <= acc;
          state <= DONE;
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_multiplier_unsigned_seq.sv
// Bench for multiplier_unsigned_seq: directed latency/handshake/reset cases plus a random scoreboard stream.
module tb_multiplier_unsigned_seq;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready, out_valid, out_ready, busy;
  logic [7:0]  a, b;
  logic [15:0] q;
  logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
  logic [3:0]  a4, b4;
  logic [7:0]  q4;

  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;
  logic [15:0] sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multiplier_unsigned_seq #(.WIDTH(8)) dut (
    .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .q(q), .busy(busy)
  );

  multiplier_unsigned_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rstn(rstn), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
    .out_valid(out_valid4), .out_ready(out_ready4), .q(q4), .busy(busy4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One operation on the 8-bit DUT; hold = cycles out_ready stays low once out_valid is seen.
  task automatic do_op(input logic [7:0] ta, input logic [7:0] tb, input int hold, output int acc_cyc);
    int          cnt;
    logic [15:0] exp;
    out_ready = (hold == 0);
    a = ta;
    b = tb;
    in_valid = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      step();
      cnt++;
    end
    check("in_ready_before_accept", 32'(in_ready), 32'd1);
    step();
    acc_cyc = cyc;
    sb.push_back(16'(ta) * 16'(tb));
    in_valid = 1'b0;
    a = 8'($urandom);
    b = 8'($urandom);
    check("busy_after_accept", 32'(busy), 32'd1);
    check("in_ready_after_accept", 32'(in_ready), 32'd0);
    cnt = 0;
    while (!out_valid && cnt < 100) begin
      a = 8'($urandom);
      b = 8'($urandom);
      step();
      cnt++;
    end
    check("latency", 32'(cnt), 32'd18);
    exp = (sb.size() > 0) ? sb.pop_front() : 16'hxxxx;
    check("product", 32'(q), 32'(exp));
    for (int k = 0; k < hold; k++) begin
      step();
      check("hold_out_valid", 32'(out_valid), 32'd1);
      check("hold_q", 32'(q), 32'(exp));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("released_out_valid", 32'(out_valid), 32'd0);
    check("released_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    int          t0, t1, t2, cnt, got, guard, seen;
    bit          acc_n, pop_n;
    logic [15:0] prod_n, qv;

    rstn = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    in_valid4 = 1'b0; out_ready4 = 1'b0; a4 = '0; b4 = '0;
    repeat (3) step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_q", 32'(q), 32'd0);
    rstn = 1'b1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_q4", 32'(q4), 32'd0);

    // Narrow instance: 0xF * 0xD
    a4 = 4'hF; b4 = 4'hD; in_valid4 = 1'b1;
    step();
    in_valid4 = 1'b0; a4 = 4'h0; b4 = 4'h0;
    cnt = 0;
    while (!out_valid4 && cnt < 50) begin
      step();
      cnt++;
    end
    check("w4_latency", 32'(cnt), 32'd6);
    check("w4_product", 32'(q4), 32'hC3);
    out_ready4 = 1'b1;
    step();
    check("w4_released", 32'(out_valid4), 32'd0);

    do_op(8'hFF, 8'hFF, 0, t0);
    do_op(8'h03, 8'h05, 0, t1);
    do_op(8'h00, 8'hB7, 0, t2);
    check("issue_interval", 32'(t2 - t1), 32'd20);
    do_op(8'hA5, 8'h3C, 5, t0);

    // Reset at edge 9 of an operation in flight
    a = 8'h12; b = 8'h34; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (8) step();
    check("mid_run_busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1;
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_q", 32'(q), 32'd0);
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    seen = 0;
    repeat (25) begin
      step();
      if (out_valid) seen++;
    end
    check("abort_no_pulse", 32'(seen), 32'd0);
    do_op(8'h12, 8'h34, 0, t0);
    check("post_abort_q", 32'(q), 32'h03A8);

    // Continuous in_valid, random operands and out_ready
    in_valid = 1'b1;
    got = 0;
    guard = 0;
    while (got < 1000 && guard < 80000) begin
      a = 8'($urandom);
      b = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      acc_n  = in_valid && in_ready;
      pop_n  = out_valid && out_ready;
      prod_n = 16'(a) * 16'(b);
      qv     = q;
      step();
      guard++;
      if (acc_n) sb.push_back(prod_n);
      if (pop_n) begin
        got++;
        if (sb.size() > 0) check("rand_q", 32'(qv), 32'(sb.pop_front()));
        else check("rand_unexpected_output", 32'd1, 32'(sb.size()));
      end
    end
    in_valid = 1'b0;
    check("rand_count", 32'(got), 32'd1000);
    check("rand_queue_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
